// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter generator: FSM state encoding
// and default geometry constants.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_ERR  = 2'd3
  } pc_state_e;

  localparam int unsigned PC_XLEN_DEF = 32;
  localparam int unsigned PC_STEP_DEF = 4;
  localparam int unsigned PC_CNT_W    = 32;

endpackage : pc_pkg

// File: rtl/pc_gen.sv
// Fetch-address generator: sequential PC stepping with stall, valid/ready
// fetch handshake, redirect with alignment checking, and an accepted-fetch count.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned      XLEN      = PC_XLEN_DEF,
  parameter logic [XLEN-1:0]  RESET_VEC = '0,
  parameter int unsigned      STEP      = PC_STEP_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_i,
  input  logic                redirect_i,
  input  logic [XLEN-1:0]     redirect_pc_i,
  input  logic                fetch_ready_i,
  output logic                fetch_valid_o,
  output logic [XLEN-1:0]     pc_o,
  output logic                misalign_o,
  output logic [PC_CNT_W-1:0] fetch_cnt_o
);

  if ((STEP < 1) || ((STEP & (STEP - 1)) != 0)) begin : g_bad_step
    $error("pc_gen: STEP must be a power of two and at least 1");
  end

  localparam logic [XLEN-1:0] STEP_INC  = XLEN'(STEP);
  localparam logic [XLEN-1:0] STEP_MASK = XLEN'(STEP - 1);

  // Alignment is a mask of the low log2(STEP) bits; STEP=1 gives an empty mask.
  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return (addr & STEP_MASK) == '0;
  endfunction

  function automatic logic [XLEN-1:0] seq_next(input logic [XLEN-1:0] addr);
    return addr + STEP_INC;
  endfunction

  pc_state_e             state_q, state_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic                  mis_q, mis_d;
  logic [PC_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  valid;
  logic                  hs;

  always_comb begin
    valid = 1'b0;
    unique case (state_q)
      ST_BOOT: valid = 1'b0;
      ST_RUN:  valid = !stall_i;
      ST_WAIT: valid = 1'b1;
      ST_ERR:  valid = 1'b0;
      default: valid = 1'b0;
    endcase
    if (rst) begin
      valid = 1'b0;
    end
  end

  assign hs = valid & fetch_ready_i;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;

    if (hs) begin
      cnt_d = cnt_q + 1'b1;
    end

    // Redirect wins over stall, a pending request and the handshake's PC step.
    if (redirect_i) begin
      pc_d = redirect_pc_i;
      if (is_aligned(redirect_pc_i)) begin
        state_d = ST_RUN;
        mis_d   = 1'b0;
      end else begin
        state_d = ST_ERR;
        mis_d   = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN, ST_WAIT: begin
          if (hs) begin
            pc_d    = seq_next(pc_q);
            state_d = ST_RUN;
          end else if (valid) begin
            state_d = ST_WAIT;
          end
        end
        ST_ERR:  state_d = ST_ERR;
        default: state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VEC;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fetch_valid_o = valid;
  assign pc_o          = pc_q;
  assign misalign_o    = mis_q;
  assign fetch_cnt_o   = cnt_q;

endmodule : pc_gen

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 0, PC value loaded on reset.
REQ-003 SHALL have parameter STEP, default 4, sequential increment in bytes; must be a power of two and at least 1.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port stall_i  input  1  data hazard; blocks issue of new fetches.
REQ-007 SHALL have port redirect_i  input  1  control hazard; load redirect_pc_i.
REQ-008 SHALL have port redirect_pc_i  input  XLEN  redirect target.
REQ-009 SHALL have port fetch_ready_i  input  1  instruction memory accepts the request.
REQ-010 SHALL have port fetch_valid_o  output  1  fetch request valid.
REQ-011 SHALL have port pc_o  output  XLEN  fetch address (current PC).
REQ-012 SHALL have port misalign_o  output  1  sticky: last redirect target not STEP-aligned.
REQ-013 SHALL have port fetch_cnt_o  output  32  count of accepted fetches.

Function
REQ-014 SHALL implement states BOOT, RUN, WAIT and ERR.
REQ-015 BOOT SHALL hold fetch_valid_o=0 and SHALL go to RUN the next cycle.
REQ-016 In RUN, fetch_valid_o SHALL equal !stall_i (combinational).
REQ-017 In WAIT and ERR, fetch_valid_o SHALL be 1 and 0 respectively.
REQ-018 A handshake SHALL be fetch_valid_o & fetch_ready_i on a clock edge.
REQ-019 On a handshake with no redirect, pc SHALL become pc+STEP modulo 2^XLEN (wraps to 0, no flag), the next state SHALL be RUN, and fetch_cnt SHALL increment.
REQ-020 If valid is high and ready is low with no redirect, the next state SHALL be WAIT with pc unchanged.
REQ-021 In WAIT, valid and pc_o SHALL stay stable until the handshake, regardless of stall_i.
REQ-022 In RUN with stall_i=1 and no redirect, pc and state SHALL hold.
REQ-023 redirect_i SHALL take priority over stall_i, WAIT and handshake in every state; the next pc SHALL be redirect_pc_i.
REQ-024 A redirect in WAIT SHALL withdraw the pending request.
REQ-025 A redirect coinciding with a handshake SHALL still increment fetch_cnt, but pc SHALL take the redirect target, not pc+STEP.
REQ-026 An aligned redirect (redirect_pc_i mod STEP == 0) SHALL set the next state to RUN and clear misalign_o.
REQ-027 A misaligned redirect SHALL load the target into pc, set the next state to ERR, and set misalign_o=1.
REQ-028 ERR SHALL hold pc and keep valid low; the only exit SHALL be an aligned redirect, and a further misaligned redirect SHALL stay in ERR with the new pc.
REQ-029 fetch_cnt_o SHALL wrap from 2^32-1 to 0.
REQ-030 Latency SHALL be one cycle from a redirect or handshake edge to the new pc_o.

Reset
REQ-031 When rst=1 at a clock edge: pc=RESET_VEC, state=BOOT, misalign_o=0, fetch_cnt_o=0, and fetch_valid_o=0 throughout.
REQ-032 rst SHALL override redirect_i and handshake on the same edge.
REQ-033 Reset mid-WAIT SHALL drop the pending request without counting it.
REQ-034 A redirect during the BOOT cycle SHALL be honoured per REQ-023.

Structure
REQ-035 The state enum and the default STEP/XLEN constants SHALL reside in shared package pc_pkg.
REQ-036 No sub-module SHALL be required: a single state register, pc register and counter.
REQ-037 The alignment test SHALL be a mask of the low log2(STEP) bits, with no divider.

Verification
REQ-038 Reset, then ready=1 for 3 cycles, stall=0 -> pc_o 0x0,0x4,0x8,0xC; fetch_cnt_o=3; valid low in the BOOT cycle.
REQ-039 In RUN at pc=0x8, ready=0 for 2 cycles, stall pulsed -> valid held 1 and pc_o=0x8 until ready=1; then pc_o=0xC and count +1.
REQ-040 redirect_i=1, target 0x100, together with stall=1 and handshake -> next pc_o=0x100, state RUN, count +1.
REQ-041 Redirect to 0x102 -> misalign_o=1, valid=0, pc_o=0x102; then redirect to 0x200 -> misalign_o=0, RUN, pc_o=0x200.
REQ-042 XLEN=8, redirect to 0xFC, two handshakes -> pc_o 0xFC then 0x00, no error.
REQ-043 rst asserted in WAIT together with redirect_i -> next pc_o=RESET_VEC, BOOT, count 0, valid 0.
